// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader's view; the master modport is the host/memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: LEN, N words (HI then LO), XOR checksum.
// Screens opcodes, writes words to instruction memory, and holds the CPU until verified.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [2:0] {
    IDLE, LEN, HI, LO, CSUM, DONE, ERR
  } loadState_e;

  loadState_e        state;
  logic [ADDR_W-1:0] lenQ;
  logic [ADDR_W-1:0] countQ;
  logic [ADDR_W-1:0] addrQ;
  logic [7:0]        hiQ;
  logic [7:0]        csumQ;
  logic [15:0]       wdataQ;
  logic              inReadyQ;
  logic              weQ;
  logic              holdQ;
  logic              doneQ;
  logic              errQ;
  logic              accept;
  logic              lastWord;

  function automatic logic illegalOp(input logic [3:0] op);
    return (op == 4'd5) || (op == 4'd6) || (op == 4'd13) || (op == 4'd14);
  endfunction

  assign accept   = bus.in_valid & inReadyQ;
  // countQ still excludes the current word: the previous word's increment lands before this LO.
  assign lastWord = (countQ + ADDR_W'(1)) == lenQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lenQ     <= '0;
      countQ   <= '0;
      addrQ    <= '0;
      hiQ      <= '0;
      csumQ    <= '0;
      wdataQ   <= '0;
      inReadyQ <= 1'b0;
      weQ      <= 1'b0;
      holdQ    <= 1'b1;
      doneQ    <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      weQ <= 1'b0;
      // word_count advances on the edge that ends the write cycle
      if (weQ) countQ <= countQ + ADDR_W'(1);

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN;
            inReadyQ <= 1'b1;
            holdQ    <= 1'b1;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
            countQ   <= '0;
            csumQ    <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            if (bus.in_data == 8'd0) begin
              state    <= ERR;
              inReadyQ <= 1'b0;
              errQ     <= 1'b1;
            end else begin
              lenQ  <= ADDR_W'(bus.in_data);
              csumQ <= bus.in_data;
              state <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            if (illegalOp(bus.in_data[7:4])) begin
              state    <= ERR;
              inReadyQ <= 1'b0;
              errQ     <= 1'b1;
            end else begin
              hiQ   <= bus.in_data;
              csumQ <= csumQ ^ bus.in_data;
              state <= LO;
            end
          end
        end
        LO: begin
          if (accept) begin
            csumQ  <= csumQ ^ bus.in_data;
            weQ    <= 1'b1;
            addrQ  <= countQ;
            wdataQ <= {hiQ, bus.in_data};
            state  <= lastWord ? CSUM : HI;
          end
        end
        CSUM: begin
          if (accept) begin
            inReadyQ <= 1'b0;
            if (bus.in_data == csumQ) begin
              state <= DONE;
              doneQ <= 1'b1;
              holdQ <= 1'b0;
            end else begin
              state <= ERR;
              errQ  <= 1'b1;
              holdQ <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          inReadyQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = inReadyQ;
  assign bus.imem_we    = weQ;
  assign bus.imem_addr  = addrQ;
  assign bus.imem_wdata = wdataQ;
  assign cpu_hold       = holdQ;
  assign done           = doneQ;
  assign err            = errQ;
  assign word_count     = countQ;

endmodule
